data_mem_responder: RTL

Memory-side responder for the core's data memory port. It accepts load/store requests over a valid/ready handshake and applies RISC-V byte, halfword and word lane rules: byte-enabled stores, and sign- or zero-extended loads. It inserts a configurable number of wait states and returns one response per request. It replaces the bare `memory` array behind the MEM stage, so the pipeline talks to a real slave with latency and error reporting.

---
 rtl/data_mem_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory slave for the core's MEM stage: valid/ready request and response,
// RISC-V byte/half/word lane handling, configurable wait states and error reporting.
module data_mem_responder #(
   parameter int ADDR_W      = 11,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;

   logic              lat_wr;
   logic [31:0]       lat_addr;
   logic [2:0]        lat_f3;
   logic [31:0]       lat_wdata;

   logic              op_wr;
   logic [31:0]       op_addr;
   logic [2:0]        op_f3;
   logic [31:0]       op_wdata;
   logic              op_err;
   logic [ADDR_W-1:0] op_idx;
   logic [1:0]        op_off;
   logic [3:0]        op_mask;
   logic [31:0]       op_wrep;

   logic              accept;
   logic              enter_resp;
   logic              commit;

   logic [31:0]       mem [DEPTH];

   function automatic logic access_err(input logic wr, input logic [31:0] addr,
                                       input logic [2:0] f3);
      logic e;
      case (f3)
         3'b011, 3'b110, 3'b111: e = 1'b1;
         default:                e = 1'b0;
      endcase
      if (wr && f3[2])                           e = 1'b1;
      if ((f3[1:0] == 2'b01) && addr[0])         e = 1'b1;
      if ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) e = 1'b1;
      if (addr[31:ADDR_W+2] != '0)               e = 1'b1;
      return e;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001 << off;
         2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Right-aligned store data replicated across lanes so the mask alone picks the target.
   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         2'b00:   d = {4{wdata[7:0]}};
         2'b01:   d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b100:  r = {24'b0, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b101:  r = {16'b0, sh[15:0]};
         default: r = word;
      endcase
      return r;
   endfunction

   // With zero wait states the accept edge is also the RESP-entry edge, so the
   // live request must be used there instead of the latched copy.
   assign op_wr    = (state == IDLE) ? req_wr     : lat_wr;
   assign op_addr  = (state == IDLE) ? req_addr   : lat_addr;
   assign op_f3    = (state == IDLE) ? req_funct3 : lat_f3;
   assign op_wdata = (state == IDLE) ? req_wdata  : lat_wdata;
   assign op_err   = access_err(op_wr, op_addr, op_f3);
   assign op_idx   = op_addr[ADDR_W+1:2];
   assign op_off   = op_addr[1:0];
   assign op_mask  = lane_mask(op_f3[1:0], op_off);
   assign op_wrep  = lane_data(op_f3[1:0], op_wdata);

   assign req_ready  = (state == IDLE);
   assign rsp_valid  = (state == RESP);
   assign accept     = (state == IDLE) && req_valid;
   assign enter_resp = (state != RESP) && (state_nxt == RESP);
   assign commit     = enter_resp && rst_n && op_wr && !op_err;

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES > 0) begin
                  state_nxt    = BUSY;
                  wait_cnt_nxt = CNT_W'(WAIT_CYCLES - 1);
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         BUSY: begin
            if (wait_cnt == '0) state_nxt = RESP;
            else                wait_cnt_nxt = wait_cnt - CNT_W'(1);
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (enter_resp) begin
            rsp_err   <= op_err;
            rsp_rdata <= (op_err || op_wr) ? 32'h0 : load_extend(mem[op_idx], op_f3, op_off);
         end
      end
   end

   always_ff @(negedge clk) begin
      if (accept) begin
         lat_wr    <= req_wr;
         lat_addr  <= req_addr;
         lat_f3    <= req_funct3;
         lat_wdata <= req_wdata;
      end
   end

   // Storage is deliberately not reset; contents survive rst_n.
   always_ff @(negedge clk) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (op_mask[b]) mem[op_idx][8*b +: 8] <= op_wrep[8*b +: 8];
         end
      end
   end

endmodule
